// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output path.
// Coefficients, datapath widths and normalizer FSM encoding.
package fir_pkg;

  localparam int NW = 17;
  localparam int QW = 17;

  localparam logic [4:0][7:0] COEFS = {
    8'd2, 8'd4, 8'd8, 8'd4, 8'd2
  };
  localparam int COEF_SUM = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_HOLD
  } norm_state_t;

  function automatic logic [7:0] sat8(
    input logic [QW-1:0] q
  );
    return (q > QW'(255)) ? 8'hff : q[7:0];
  endfunction

endpackage

// File: rtl/fir_seq_div.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// done is asserted in the cycle of the final step with quotient valid.
module fir_seq_div
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [7:0]    divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  logic [NW-1:0] n_q;
  logic [7:0]    r_q;
  logic [QW-1:0] q_q;
  logic [4:0]    step_q;
  logic          busy_q;

  logic [8:0]    rem_sh;
  logic [8:0]    rem_nx;
  logic          ge;
  logic [QW-1:0] quo_nx;

  always_comb begin
    rem_sh = {r_q, n_q[NW-1]};
    ge     = rem_sh >= {1'b0, divisor};
    rem_nx = ge ? (rem_sh - {1'b0, divisor}) : rem_sh;
    quo_nx = {q_q[QW-2:0], ge};
  end

  assign busy     = busy_q;
  assign done     = busy_q && (step_q == 5'd16);
  assign quotient = quo_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      n_q    <= num;
      r_q    <= '0;
      q_q    <= '0;
      step_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      n_q    <= n_q << 1;
      r_q    <= rem_nx[7:0];
      q_q    <= quo_nx;
      step_q <= step_q + 5'd1;
      if (step_q == 5'd16)
        busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_out_normalizer.sv
// Decimates filter output, divides by coefficient sum with rounding,
// saturates to 8 bits and presents it through a valid/ready register.
module fir_out_normalizer
  import fir_pkg::*;
#(
  parameter int DECIM = 32,
  parameter int GAIN  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] y_in,
  input  logic        y_valid,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        overrun
);

  localparam logic [7:0]    DLAST = 8'(DECIM - 1);
  localparam logic [7:0]    GDIV  = 8'(GAIN);
  localparam logic [NW-1:0] HALF  = NW'(GAIN / 2);

  norm_state_t state, nstate;

  logic [7:0]    dcnt;
  logic          keep;
  logic          free;
  logic [7:0]    hold_q;

  logic          div_start;
  logic          div_busy;
  logic          div_done;
  logic [QW-1:0] div_q;
  logic [NW-1:0] num;

  logic          wr;
  logic [7:0]    wr_data;
  logic          hold_ld;
  logic          drop;

  assign keep = y_valid && (dcnt == 8'd0);
  assign free = !dout_valid || dout_ready;
  assign num  = {1'b0, y_in} + HALF;

  always_ff @(posedge clk) begin
    if (reset)
      dcnt <= '0;
    else if (y_valid)
      dcnt <= (dcnt == DLAST) ? 8'd0 : dcnt + 8'd1;
  end

  fir_seq_div u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .num      (num),
    .divisor  (GDIV),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: if (keep) nstate = S_DIV;
      S_DIV: begin
        if (div_done)
          nstate = free ? S_IDLE : S_HOLD;
        else if (!div_busy)
          nstate = S_IDLE;
      end
      S_HOLD: if (free) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    div_start = 1'b0;
    wr        = 1'b0;
    wr_data   = hold_q;
    hold_ld   = 1'b0;
    drop      = 1'b0;
    unique case (state)
      S_IDLE: div_start = keep;
      S_DIV: begin
        drop = keep;
        if (div_done) begin
          wr_data = sat8(div_q);
          wr      = free;
          hold_ld = !free;
        end
      end
      S_HOLD: begin
        drop = keep;
        wr   = free;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      hold_q     <= '0;
    end else begin
      if (wr) begin
        dout       <= wr_data;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (hold_ld)
        hold_q <= sat8(div_q);
      if (drop)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_normalizer.sv
// Directed and randomized bench for fir_out_normalizer.
// Expected results come from integer rounding arithmetic.
module tb_fir_out_normalizer;

  localparam int DECIM = 32;
  localparam int GAIN  = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] y_in;
  logic        y_valid;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;

  int nchk  = 0;
  int nfail = 0;
  int mcnt  = 0;
  int dv_seen = 0;
  int exp_q[$];
  int got_q[$];

  fir_out_normalizer #(.DECIM(DECIM), .GAIN(GAIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid === 1'b1) dv_seen++;
    if (dout_valid === 1'b1 && dout_ready === 1'b1)
      got_q.push_back(int'(dout));
  end

  function automatic int model(input int y);
    int q;
    q = (y + GAIN / 2) / GAIN;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] y, input bit accept);
    y_in = y;
    y_valid = 1'b1;
    if (mcnt == 0 && accept) exp_q.push_back(model(int'(y)));
    mcnt = (mcnt + 1) % DECIM;
    step();
    y_valid = 1'b0;
  endtask

  task automatic fill_to_zero();
    while (mcnt != 0) begin
      if ($urandom_range(0, 3) != 0) send(16'($urandom), 1'b1);
      else step();
    end
  endtask

  task automatic idle(input int n);
    y_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    y_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    mcnt = 0;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int early;
    logic [7:0] held;
    reset = 1'b1;
    y_in = '0;
    y_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (3) step();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    mcnt = 0;
    got_q.delete();

    // latency: first sample after reset is kept
    early = 0;
    send(16'd5100, 1'b1);
    if (dout_valid !== 1'b0) early++;
    for (int k = 2; k <= 19; k++) begin
      step();
      if (k < 18 && dout_valid !== 1'b0) early++;
      if (k == 18) begin
        chk("lat_valid18", dout_valid, 1);
        chk("lat_dout", dout, 255);
      end
      if (k == 19) chk("lat_valid19", dout_valid, 0);
    end
    chk("lat_early", early, 0);
    compare("lat_q");

    // directed rounding / saturation values
    fill_to_zero();
    send(16'd100, 1'b1);   fill_to_zero();
    send(16'd30, 1'b1);    fill_to_zero();
    send(16'd9, 1'b1);     fill_to_zero();
    send(16'd10, 1'b1);    fill_to_zero();
    send(16'd29, 1'b1);    fill_to_zero();
    send(16'd65535, 1'b1); fill_to_zero();
    send(16'd5090, 1'b1);  fill_to_zero();
    idle(25);
    chk("dir_overrun", overrun, 0);
    compare("dir");

    // random stream, one result per DECIM inputs
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) send(16'($urandom_range(0, 6000)), 1'b1);
      else send(16'($urandom), 1'b1);
      fill_to_zero();
    end
    idle(25);
    chk("rnd_overrun", overrun, 0);
    compare("rnd");

    // backpressure: hold, then overrun on third kept sample
    dout_ready = 1'b0;
    send(16'($urandom_range(0, 5000)), 1'b1);
    fill_to_zero();
    held = dout;
    chk("bp_first_valid", dout_valid, 1);
    send(16'($urandom_range(0, 5000)), 1'b1);
    fill_to_zero();
    chk("bp_stable", dout, held);
    chk("bp_first_val", dout, exp_q[0]);
    chk("bp_no_overrun", overrun, 0);
    send(16'($urandom), 1'b0);
    chk("bp_overrun", overrun, 1);
    idle(3);
    chk("bp_stable2", dout, held);
    dout_ready = 1'b1;
    idle(25);
    compare("bp");
    chk("bp_sticky", overrun, 1);

    // reset in the middle of a division
    do_reset();
    chk("rst2_overrun", overrun, 0);
    chk("rst2_dout", dout, 0);
    got_q.delete();
    exp_q.delete();
    send(16'd3000, 1'b0);
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mcnt = 0;
    dv_seen = 0;
    idle(30);
    chk("mid_dv_seen", dv_seen, 0);
    chk("mid_got", got_q.size(), 0);
    send(16'd777, 1'b1);
    idle(25);
    compare("mid_after");
    chk("mid_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
